// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared definitions for the memory-port arbiter: FSM state
//               encoding, grant-owner encoding, default widths and a
//               saturating-increment helper for the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Default configuration
    localparam int c_addr_w_def     = 21;
    localparam int c_data_w_def     = 32;
    localparam int c_mem_lat_def    = 2;
    localparam int c_max_streak_def = 4;

    // Streak and wait counters both cover the 1..15 range
    localparam int c_cnt_w = 4;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_issue = 2'd1;
    localparam state_t c_st_wait  = 2'd2;
    localparam state_t c_st_resp  = 2'd3;

    // Grant owner encoding
    typedef logic owner_t;
    localparam owner_t c_own_if = 1'b0;
    localparam owner_t c_own_dm = 1'b1;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of every handshake/bus signal around the arbiter.
//               Fetch port   : if_req, if_addr, if_ack, if_rdata
//               Data port    : dm_req, dm_we, dm_addr, dm_wdata, dm_ack, dm_rdata
//               Memory port  : mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
//               Status       : busy
//               Modport slave  - the arbiter's view.
//               Modport master - the requesters' and memory's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_def,
    parameter int DATA_W = c_data_w_def
);
    // Instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    // Load/store requester
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    // Single-port memory
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter status
    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_priority_sel.sv
`default_nettype none
// ============================================================================
// Module      : arb_priority_sel
// Description : Combinational winner select and streak-counter update.
//               Data side normally wins; once MAX_STREAK consecutive data
//               grants have been made while fetch waited, fetch wins.
// Ports       : i_if_req, i_dm_req  - pending requests
//               i_streak            - current streak count
//               o_grant_valid       - at least one request present
//               o_grant_owner       - winner (c_own_if / c_own_dm)
//               o_streak_next       - streak value to store if granted
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = c_max_streak_def
) (
    input  logic               i_if_req,
    input  logic               i_dm_req,
    input  logic [c_cnt_w-1:0] i_streak,
    output logic               o_grant_valid,
    output owner_t             o_grant_owner,
    output logic [c_cnt_w-1:0] o_streak_next
);

    localparam logic [c_cnt_w-1:0] c_streak_max = c_cnt_w'(MAX_STREAK);

    logic w_fetch_starved;

    assign w_fetch_starved = i_if_req && (i_streak >= c_streak_max);

    always_comb begin
        o_grant_valid = i_if_req | i_dm_req;
        o_grant_owner = c_own_if;
        o_streak_next = i_streak;

        if (i_dm_req && !w_fetch_starved) begin
            o_grant_owner = c_own_dm;
        end

        if (o_grant_valid) begin
            if (o_grant_owner == c_own_if) begin
                o_streak_next = '0;
            end else if (i_if_req) begin
                // Data beat a waiting fetch: extend the streak, sticking at max
                o_streak_next = (i_streak >= c_streak_max) ? c_streak_max
                                                           : i_streak + 1'b1;
            end else begin
                // Nobody was waiting, so there is no streak to track
                o_streak_next = '0;
            end
        end
    end

endmodule : arb_priority_sel
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port memory between the instruction-fetch
//               unit and the load/store unit. A four-state FSM
//               (IDLE/ISSUE/WAIT/RESP) sequences each access and returns read
//               data or a write acknowledgement to the winner.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous reset, active low
//               bus  - mem_port_arbiter_if.slave (fetch, data, memory, busy)
//               stat_if_grants / stat_dm_grants / stat_if_stall
//                    - saturating statistics, only with MEM_ARB_STATS_EN
// Options     : `define MEM_ARB_STATS_EN to add the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w_def,
    parameter int DATA_W     = c_data_w_def,
    parameter int MEM_LAT    = c_mem_lat_def,
    parameter int MAX_STREAK = c_max_streak_def
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_if_grants,
    output logic [15:0]       stat_dm_grants,
    output logic [15:0]       stat_if_stall
`endif
);

    // Wait-counter load value; reads spend this many extra cycles in WAIT
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(MEM_LAT - 1);

    state_t              r_state;
    state_t              w_state_next;
    owner_t              r_owner;
    logic [c_cnt_w-1:0]  r_streak;
    logic [c_cnt_w-1:0]  r_wait_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_grant_valid;
    owner_t              w_grant_owner;
    logic [c_cnt_w-1:0]  w_streak_next;
    logic                w_grant_fire;

    logic                w_mem_en;
    logic                w_busy;
    logic                w_if_ack;
    logic                w_dm_ack;

    // ------------------------------------------------------------------
    // Winner select
    // ------------------------------------------------------------------
    arb_priority_sel #(
        .MAX_STREAK (MAX_STREAK)
    ) u_sel (
        .i_if_req      (bus.if_req),
        .i_dm_req      (bus.dm_req),
        .i_streak      (r_streak),
        .o_grant_valid (w_grant_valid),
        .o_grant_owner (w_grant_owner),
        .o_streak_next (w_streak_next)
    );

    assign w_grant_fire = (r_state == c_st_idle) && w_grant_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_grant_valid) begin
                    w_state_next = c_st_issue;
                end
            end
            c_st_issue: begin
                // Writes need no data back; single-cycle reads skip WAIT
                if (r_mem_we || (MEM_LAT == 1)) begin
                    w_state_next = c_st_resp;
                end else begin
                    w_state_next = c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = c_st_resp;
                end
            end
            c_st_resp: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_en = 1'b0;
        w_busy   = 1'b1;
        w_if_ack = 1'b0;
        w_dm_ack = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_busy = 1'b0;
            end
            c_st_issue: begin
                w_mem_en = 1'b1;
            end
            c_st_resp: begin
                w_if_ack = (r_owner == c_own_if);
                w_dm_ack = (r_owner == c_own_dm);
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, memory-request and read-data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner     <= c_own_if;
            r_streak    <= '0;
            r_wait_cnt  <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_grant_valid) begin
                        r_owner  <= w_grant_owner;
                        r_streak <= w_streak_next;
                        if (w_grant_owner == c_own_dm) begin
                            r_mem_addr  <= bus.dm_addr;
                            r_mem_we    <= bus.dm_we;
                            r_mem_wdata <= bus.dm_wdata;
                        end else begin
                            // Fetch is always a read
                            r_mem_addr  <= bus.if_addr;
                            r_mem_we    <= 1'b0;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                c_st_issue: begin
                    if (!r_mem_we) begin
                        r_wait_cnt <= c_wait_load;
                        if (MEM_LAT == 1) begin
                            if (r_owner == c_own_if) begin
                                r_if_rdata <= bus.mem_rdata;
                            end else begin
                                r_dm_rdata <= bus.mem_rdata;
                            end
                        end
                    end
                end
                c_st_wait: begin
                    if (r_wait_cnt == '0) begin
                        if (r_owner == c_own_if) begin
                            r_if_rdata <= bus.mem_rdata;
                        end else begin
                            r_dm_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                c_st_resp: begin
                    // Read data is only presented alongside its ack
                    r_if_rdata <= '0;
                    r_dm_rdata <= '0;
                end
                default: begin
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign bus.if_ack    = w_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_ack    = w_dm_ack;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = w_busy;

`ifdef MEM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters
    // ------------------------------------------------------------------
    logic [15:0] r_stat_if_grants;
    logic [15:0] r_stat_dm_grants;
    logic [15:0] r_stat_if_stall;
    logic        w_if_in_resp;

    assign w_if_in_resp = (r_state == c_st_resp) && (r_owner == c_own_if);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_if_grants <= '0;
            r_stat_dm_grants <= '0;
            r_stat_if_stall  <= '0;
        end else begin
            if (w_grant_fire && (w_grant_owner == c_own_if)) begin
                r_stat_if_grants <= sat_inc16(r_stat_if_grants);
            end
            if (w_grant_fire && (w_grant_owner == c_own_dm)) begin
                r_stat_dm_grants <= sat_inc16(r_stat_dm_grants);
            end
            if (bus.if_req && !w_if_in_resp) begin
                r_stat_if_stall <= sat_inc16(r_stat_if_stall);
            end
        end
    end

    assign stat_if_grants = r_stat_if_grants;
    assign stat_dm_grants = r_stat_dm_grants;
    assign stat_if_stall  = r_stat_if_stall;
`else
    // Grant strobe only feeds the statistics block
    logic w_unused;
    assign w_unused = w_grant_fire;
`endif

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with a
//               two-stage pipelined memory model (MEM_LAT = 2).
//               Define MEM_ARB_STATS_EN to also exercise the statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 21;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int MAX_STREAK = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_if_grants;
    logic [15:0] stat_dm_grants;
    logic [15:0] stat_if_stall;
`endif

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .MAX_STREAK (MAX_STREAK)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_dm_grants (stat_dm_grants),
        .stat_if_stall  (stat_if_stall)
`endif
    );

    // ------------------------------------------------------------------
    // Memory model: data appears MEM_LAT cycles after the mem_en cycle,
    // and a poison value otherwise so mistimed captures are visible.
    // ------------------------------------------------------------------
    logic [31:0] mem_arr [0:511];
    logic [31:0] p1, p2;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;

    always @(posedge clk) begin
        v1 <= bus.mem_en && !bus.mem_we;
        p1 <= mem_arr[bus.mem_addr[8:0]];
        v2 <= v1;
        p2 <= p1;
        if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[8:0]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = v2 ? p2 : 32'h0BAD_0BAD;

    // Memory-access log and independent fetch-stall count
    int          en_cnt    = 0;
    int          stall_cnt = 0;
    logic [20:0] last_addr;
    logic        last_we;
    logic [31:0] last_wdata;

    always @(negedge clk) begin
        if (bus.mem_en === 1'b1) begin
            en_cnt++;
            last_addr  = bus.mem_addr;
            last_we    = bus.mem_we;
            last_wdata = bus.mem_wdata;
        end
        if (rst !== 1'b1) stall_cnt = 0;
        else if (bus.if_req && !bus.if_ack) stall_cnt++;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until an ack shows (bounded); n counts the edges taken
    task automatic wait_ack(output logic gi, output logic gd, output int n);
        n  = 0;
        gi = 1'b0;
        gd = 1'b0;
        while (!gi && !gd && n < 40) begin
            tick();
            n++;
            gi = bus.if_ack;
            gd = bus.dm_ack;
        end
    endtask

    // One isolated read from either side: latency, ack owner, data
    task automatic read_txn(input string tag, input logic is_if,
                            input logic [20:0] addr, input logic [31:0] exp);
        logic gi, gd;
        int   n;
        if (is_if) begin
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end else begin
            bus.dm_addr = addr;
            bus.dm_we   = 1'b0;
            bus.dm_req  = 1'b1;
        end
        wait_ack(gi, gd, n);
        chk({tag, "_lat"}, 64'(n), 64'd4);
        chk({tag, "_ack"}, {62'd0, gi, gd}, is_if ? 64'd2 : 64'd1);
        chk({tag, "_rdata"}, is_if ? 64'(bus.if_rdata) : 64'(bus.dm_rdata), 64'(exp));
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic       gi, gd;
        int         n, e0;
        logic [9:0] order;

        for (int i = 0; i < 512; i++) mem_arr[i] = 32'hA5A5_0000 | i;
        mem_arr[9'h102] = 32'hDEAD_BEEF;

        // Reset with both requests pending
        rst          = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 21'h000102;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 21'h000010;
        bus.dm_wdata = '0;
        tick();
        tick();
        chk("rst_if_ack",    64'(bus.if_ack),    64'd0);
        chk("rst_dm_ack",    64'(bus.dm_ack),    64'd0);
        chk("rst_if_rdata",  64'(bus.if_rdata),  64'd0);
        chk("rst_dm_rdata",  64'(bus.dm_rdata),  64'd0);
        chk("rst_mem_en",    64'(bus.mem_en),    64'd0);
        chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
        chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_en_cnt",    64'(en_cnt),        64'd0);

        // Release: data side must win first
        rst = 1'b1;
        tick();
        chk("rel_mem_en",   64'(bus.mem_en),   64'd1);
        chk("rel_mem_addr", 64'(bus.mem_addr), 64'h10);
        chk("rel_busy",     64'(bus.busy),     64'd1);
        bus.if_req = 1'b0;
        wait_ack(gi, gd, n);
        chk("rel_dm_ack",   {62'd0, gi, gd},   64'd1);
        chk("rel_lat",      64'(n),            64'd3);
        chk("rel_dm_rdata", 64'(bus.dm_rdata), 64'hA5A5_0010);
        bus.dm_req = 1'b0;
        tick();
        chk("rel_rdata_clr", 64'(bus.dm_rdata), 64'd0);
        chk("rel_idle",      64'(bus.busy),     64'd0);

        // Single fetch
        e0 = en_cnt;
        read_txn("fetch", 1'b1, 21'h000102, 32'hDEAD_BEEF);
        chk("fetch_en_once",   64'(en_cnt - e0), 64'd1);
        chk("fetch_mem_addr",  64'(last_addr),   64'h102);
        chk("fetch_mem_we",    64'(last_we),     64'd0);
        chk("fetch_rdata_clr", 64'(bus.if_rdata), 64'd0);
        chk("fetch_ack_clr",   64'(bus.if_ack),  64'd0);

        // Store
        e0 = en_cnt;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 21'h000002;
        bus.dm_wdata = 32'h0000_00A5;
        bus.dm_req   = 1'b1;
        wait_ack(gi, gd, n);
        chk("store_ack",       {62'd0, gi, gd},   64'd1);
        chk("store_lat",       64'(n),            64'd2);
        chk("store_rdata",     64'(bus.dm_rdata), 64'd0);
        chk("store_en_once",   64'(en_cnt - e0),  64'd1);
        chk("store_mem_we",    64'(last_we),      64'd1);
        chk("store_mem_addr",  64'(last_addr),    64'h2);
        chk("store_mem_wdata", 64'(last_wdata),   64'hA5);
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        tick();
        read_txn("loadback", 1'b0, 21'h000002, 32'h0000_00A5);

        // Contention: both held, expect DM x4 then IF, repeating
        e0          = en_cnt;
        order       = '0;
        bus.if_addr = 21'h000102;
        bus.dm_addr = 21'h000020;
        bus.dm_we   = 1'b0;
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_ack(gi, gd, n);
            chk("cont_one_ack", 64'(gi ^ gd), 64'd1);
            order[k] = gd;
            chk("cont_rdata", gd ? 64'(bus.dm_rdata) : 64'(bus.if_rdata),
                gd ? 64'hA5A5_0020 : 64'hDEAD_BEEF);
            if (k == 9) begin
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
            end
        end
        tick();
        chk("cont_order", 64'(order), 64'(10'b0111101111));
        chk("cont_en_cnt", 64'(en_cnt - e0), 64'd10);

        // Reset in the middle of a read
        bus.dm_addr = 21'h000030;
        bus.dm_req  = 1'b1;
        tick();
        tick();
        chk("mid_in_wait_busy", 64'(bus.busy),   64'd1);
        chk("mid_in_wait_en",   64'(bus.mem_en), 64'd0);
        rst = 1'b0;
        tick();
        chk("mid_rst_busy",   64'(bus.busy),     64'd0);
        chk("mid_rst_ack",    64'(bus.dm_ack),   64'd0);
        chk("mid_rst_rdata",  64'(bus.dm_rdata), 64'd0);
        chk("mid_rst_addr",   64'(bus.mem_addr), 64'd0);
        bus.dm_req = 1'b0;
        tick();
        chk("mid_rst_noack1", 64'(bus.dm_ack), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_post_idle",  64'(bus.busy),   64'd0);
        chk("mid_post_noack", 64'(bus.dm_ack), 64'd0);
        read_txn("mid_next", 1'b0, 21'h000030, 32'hA5A5_0030);

        // 3 fetch and 5 data transactions since the last reset, incl. one
        // contended round so fetch accumulates stall cycles
        bus.if_addr = 21'h000040;
        bus.dm_addr = 21'h000050;
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
        wait_ack(gi, gd, n);
        chk("both_dm_first", {62'd0, gi, gd},   64'd1);
        chk("both_dm_rdata", 64'(bus.dm_rdata), 64'hA5A5_0050);
        bus.dm_req = 1'b0;
        wait_ack(gi, gd, n);
        chk("both_if_next",  {62'd0, gi, gd},   64'd2);
        chk("both_if_lat",   64'(n),            64'd5);
        chk("both_if_rdata", 64'(bus.if_rdata), 64'hA5A5_0040);
        bus.if_req = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            read_txn("dm_seq", 1'b0, 21'(9'h060 + k), 32'hA5A5_0060 + k);
        end
        for (int k = 0; k < 2; k++) begin
            read_txn("if_seq", 1'b1, 21'(9'h070 + k), 32'hA5A5_0070 + k);
        end

`ifdef MEM_ARB_STATS_EN
        chk("stat_if_grants", 64'(stat_if_grants), 64'd3);
        chk("stat_dm_grants", 64'(stat_dm_grants), 64'd5);
        chk("stat_if_stall",  64'(stat_if_stall),  64'(stall_cnt));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
